led_stream_tx: RTL and testbench
================================

// Module: led_stream_tx
// PURPOSE
//  Serializes the 12x16 tile-state matrix produced by the engine into the
//  single-wire addressable-LED protocol driving the playfield panel.
//  - 1250 ns bit cell: '0' = 400 ns high / 850 ns low; '1' = 800 ns high / 450 ns low.
//  - Each frame is followed by a >50 us low latch period.
//  Sits between the engine (state) and the panel data pin; frame requests come from game-frame logic.
// PARAMETERS
//  ROWS        12        matrix rows (row 0 = top, first pixel on strip)
//  COLS        16        matrix columns
//  T0H_CYC     20        clk cycles high for a '0' bit (400 ns @ 50 MHz)
//  T1H_CYC     40        clk cycles high for a '1' bit (800 ns @ 50 MHz)
//  BIT_CYC     63        clk cycles per bit cell (1260 ns @ 50 MHz)
//  RST_CYC     3000      clk cycles of latch low after the last bit (60 us)
//  ON_GRB      24'h00FF00  colour sent for a state bit of 1; 0 sends 24'h000000
//  SERPENTINE  1         1: odd rows are wired right-to-left; 0: all rows left-to-right
// PORTS
//  clk          in   1          system clock
//  rst_n        in   1          asynchronous active-low reset
//  state        in   ROWS*COLS  tile matrix; bit r*COLS+c = row r, column c
//  frame_start  in   1          1-cycle request to transmit the current state
//  busy         out  1          high from accepted start until done
//  frame_done   out  1          1-cycle pulse after the latch period ends
//  dout         out  1          LED data line
// BEHAVIOUR
//  Reset (async, rst_n=0): dout=0, busy=0, frame_done=0, FSM=IDLE, all counters 0.
//  Reset mid-frame aborts immediately; no partial completion pulse.
//  FSM states:
//  - IDLE: waits for frame_start=1.
//    On start, snapshot state into an internal register; pix=0, bit=23; go to HIGH.
//    busy=1 from the next cycle.
//  - HIGH: dout=1 for T0H_CYC or T1H_CYC cycles, chosen by the current bit.
//    First dout rise occurs the cycle after frame_start is sampled.
//  - LOW: dout=0 for the remainder, so the cell is exactly BIT_CYC cycles.
//    Then advance: bit 23..0 (MSB first, G[7:0] R[7:0] B[7:0]).
//    After bit 0: pix++ and bit=23.
//    After the last pixel (ROWS*COLS-1) bit 0, go to LATCH.
//  - LATCH: dout=0 for RST_CYC cycles, then frame_done=1 for one cycle.
//    In that same cycle busy=0 and FSM returns to IDLE.
//  Pixel mapping: r = pix / COLS, k = pix % COLS.
//  - c = (SERPENTINE && r odd) ? COLS-1-k : k.
//  - Colour = snap[r*COLS+c] ? ON_GRB : 0.
//  - Use row/col counters; no divider.
//  Snapshot: state changes during a frame do not affect it.
//  frame_start while busy is ignored, including in the frame_done cycle.
//  frame_start in the first IDLE cycle after frame_done is accepted.
//  Frame length: ROWS*COLS*24*BIT_CYC + RST_CYC cycles (default 293304).
//  - Start to frame_done is exactly this value + 1 cycle.
//  Counters: bit-cell counter covers BIT_CYC-1; latch counter covers RST_CYC-1.
//  - Widths come from $clog2 of those values.
//  - No wrap is ever observable on dout.
//  Parameter legality (elaboration check): T0H_CYC < T1H_CYC < BIT_CYC.
// TESTING
//  1 Only state[0]=1, start: first 24 cells are 8x'0', 8x'1', 8x'0' (highs 20,40,20).
//    Remaining 4584 cells are '0'.
//  2 state=0, start: 4608 cells with 20-cycle highs, then 3000 low cycles.
//    frame_done exactly 293305 cycles after start; busy falls with it.
//  3 SERPENTINE=1, only bit r=1,c=0 (bit 16) set: pixel index 31 is the only ON_GRB pixel.
//    With SERPENTINE=0 it is pixel 16.
//  4 Start pulse mid-frame plus state flipped to all-1 mid-frame:
//    no restart; output still matches the original snapshot.
//  5 rst_n low at pixel 100: dout=0 and busy=0 asynchronously, no frame_done.
//    Start after release gives a full correct frame.
//  6 frame_start held high continuously: back-to-back frames.
//    Each frame ends with 3000 low cycles; next first rise follows 1 IDLE cycle.

Source files
------------

// File: rtl/led_stream_tx.sv
`default_nettype none
// ============================================================================
// Module  : led_stream_tx
// Brief   : Serialises the tile-state matrix onto a single-wire addressable-LED
//           data line (fixed-width bit cells, MSB-first GRB, latch gap).
// Revision: 1.0 - initial release
// ============================================================================
module led_stream_tx #(
   parameter int          ROWS       = 12,
   parameter int          COLS       = 16,
   parameter int          T0H_CYC    = 20,
   parameter int          T1H_CYC    = 40,
   parameter int          BIT_CYC    = 63,
   parameter int          RST_CYC    = 3000,
   parameter logic [23:0] ON_GRB     = 24'h00FF00,
   parameter bit          SERPENTINE = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ROWS*COLS-1:0] state,
   input  logic                 frame_start,
   output logic                 busy,
   output logic                 frame_done,
   output logic                 dout
);

   localparam int NPIX = ROWS * COLS;
   localparam int CNTW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam int LATW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;

   localparam logic [CNTW-1:0] c_t0_last   = CNTW'(T0H_CYC - 1);
   localparam logic [CNTW-1:0] c_t1_last   = CNTW'(T1H_CYC - 1);
   localparam logic [CNTW-1:0] c_cell_last = CNTW'(BIT_CYC - 1);
   localparam logic [LATW-1:0] c_lat_last  = LATW'(RST_CYC - 1);
   localparam logic [RW-1:0]   c_row_last  = RW'(ROWS - 1);
   localparam logic [CW-1:0]   c_col_last  = CW'(COLS - 1);
   localparam logic [IW-1:0]   c_row_step  = IW'(COLS);
   localparam logic [23:0]     c_on        = ON_GRB;

   if (!(T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC)) begin : g_bad_timing
      $fatal(1, "led_stream_tx: need T0H_CYC < T1H_CYC < BIT_CYC");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_HIGH  = 2'd1,
      S_LOW   = 2'd2,
      S_LATCH = 2'd3
   } fsm_e;

   fsm_e           fsm_q, fsm_d;
   logic [NPIX-1:0] snap_q, snap_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [LATW-1:0] lat_q, lat_d;
   logic [4:0]      bit_q, bit_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   logic [IW-1:0]   base_q, base_d;
   logic            dout_q, dout_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            w_rev;
   logic [CW-1:0]   w_col;
   logic [IW-1:0]   w_idx;
   logic            w_bit;
   logic [CNTW-1:0] w_hi_last;

   // Physical column follows the strip direction; base_q tracks row*COLS.
   assign w_rev     = SERPENTINE && row_q[0];
   assign w_col     = w_rev ? (c_col_last - col_q) : col_q;
   assign w_idx     = base_q + IW'(w_col);
   assign w_bit     = snap_q[w_idx] & c_on[bit_q];
   assign w_hi_last = w_bit ? c_t1_last : c_t0_last;

   always_comb begin
      fsm_d  = fsm_q;
      snap_d = snap_q;
      cnt_d  = cnt_q;
      lat_d  = lat_q;
      bit_d  = bit_q;
      row_d  = row_q;
      col_d  = col_q;
      base_d = base_q;
      done_d = 1'b0;
      case (fsm_q)
         S_IDLE: begin
            // done_q marks the completion cycle, in which a new start is refused.
            if (frame_start && !done_q) begin
               snap_d = state;
               bit_d  = 5'd23;
               cnt_d  = '0;
               row_d  = '0;
               col_d  = '0;
               base_d = '0;
               fsm_d  = S_HIGH;
            end
         end
         S_HIGH: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == w_hi_last) fsm_d = S_LOW;
         end
         S_LOW: begin
            if (cnt_q == c_cell_last) begin
               cnt_d = '0;
               fsm_d = S_HIGH;
               if (bit_q == 5'd0) begin
                  bit_d = 5'd23;
                  if (col_q == c_col_last) begin
                     col_d = '0;
                     if (row_q == c_row_last) begin
                        fsm_d = S_LATCH;
                        lat_d = '0;
                     end else begin
                        row_d  = row_q + 1'b1;
                        base_d = base_q + c_row_step;
                     end
                  end else begin
                     col_d = col_q + 1'b1;
                  end
               end else begin
                  bit_d = bit_q - 5'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_LATCH: begin
            if (lat_q == c_lat_last) begin
               fsm_d  = S_IDLE;
               done_d = 1'b1;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         default: fsm_d = S_IDLE;
      endcase
      dout_d = (fsm_d == S_HIGH);
      busy_d = (fsm_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q  <= S_IDLE;
         snap_q <= '0;
         cnt_q  <= '0;
         lat_q  <= '0;
         bit_q  <= '0;
         row_q  <= '0;
         col_q  <= '0;
         base_q <= '0;
         dout_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         snap_q <= snap_d;
         cnt_q  <= cnt_d;
         lat_q  <= lat_d;
         bit_q  <= bit_d;
         row_q  <= row_d;
         col_q  <= col_d;
         base_q <= base_d;
         dout_q <= dout_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign dout       = dout_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_led_stream_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_stream_tx
// Brief   : Self-checking bench for led_stream_tx (serpentine and linear).
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_stream_tx;

   localparam int          ROWS  = 4;
   localparam int          COLS  = 4;
   localparam int          T0H   = 2;
   localparam int          T1H   = 4;
   localparam int          BITC  = 7;
   localparam int          RSTC  = 20;
   localparam logic [23:0] ON    = 24'h00FF00;
   localparam int          NPIX  = ROWS * COLS;
   localparam int          NBITS = NPIX * 24;
   localparam int          FRAME = NBITS * BITC + RSTC;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NPIX-1:0]      state_r = '0;
   logic                 frame_start = 1'b0;
   logic                 busy_s, fd_s, dout_s;
   logic                 busy_l, fd_l, dout_l;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   led_stream_tx #(.ROWS(ROWS), .COLS(COLS), .T0H_CYC(T0H), .T1H_CYC(T1H),
                   .BIT_CYC(BITC), .RST_CYC(RSTC), .ON_GRB(ON), .SERPENTINE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .state(state_r), .frame_start(frame_start),
      .busy(busy_s), .frame_done(fd_s), .dout(dout_s));

   led_stream_tx #(.ROWS(ROWS), .COLS(COLS), .T0H_CYC(T0H), .T1H_CYC(T1H),
                   .BIT_CYC(BITC), .RST_CYC(RSTC), .ON_GRB(ON), .SERPENTINE(1'b0)) dut_lin (
      .clk(clk), .rst_n(rst_n), .state(state_r), .frame_start(frame_start),
      .busy(busy_l), .frame_done(fd_l), .dout(dout_l));

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endfunction

   // Expected bit streams for the serpentine (s) and linear (l) instances.
   bit exp_s[$];
   bit exp_l[$];

   // on_* : index of the single lit pixel, -1 none lit, -2 all lit
   task automatic push_frame(int on_s, int on_l);
      logic [23:0] col;
      col = ON;
      for (int p = 0; p < NPIX; p++) begin
         for (int b = 23; b >= 0; b--) begin
            exp_s.push_back((on_s == -2 || on_s == p) ? col[b] : 1'b0);
            exp_l.push_back((on_l == -2 || on_l == p) ? col[b] : 1'b0);
         end
      end
   endtask

   // Line monitor: decodes cells by high time and checks cell/latch lengths.
   logic mon_prev[2] = '{1'b0, 1'b0};
   logic mon_in[2]   = '{1'b0, 1'b0};
   int   mon_hi[2]   = '{0, 0};
   int   mon_lo[2]   = '{0, 0};
   int   mon_last[2] = '{0, 0};
   int   mon_nb[2]   = '{0, 0};
   logic mon_d, mon_f, mon_e;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_s.delete();
         exp_l.delete();
         for (int m = 0; m < 2; m++) begin
            mon_prev[m] = 1'b0; mon_in[m] = 1'b0; mon_hi[m] = 0;
            mon_lo[m] = 0; mon_nb[m] = 0;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            mon_d = (m == 0) ? dout_s : dout_l;
            mon_f = (m == 0) ? fd_s : fd_l;
            if (mon_d && !mon_prev[m]) begin
               if (mon_in[m]) check("cell_len", mon_hi[m] + mon_lo[m], BITC);
               mon_hi[m] = 0;
               mon_lo[m] = 0;
               mon_in[m] = 1'b1;
            end
            if (mon_d) begin
               mon_hi[m]++;
            end else begin
               if (mon_prev[m]) begin
                  mon_last[m] = mon_hi[m];
                  mon_nb[m]++;
                  if (mon_hi[m] != T0H && mon_hi[m] != T1H) begin
                     check("high_len", mon_hi[m], T0H);
                  end else if ((m == 0 && exp_s.size() == 0) || (m == 1 && exp_l.size() == 0)) begin
                     check("stream_overrun", 1, 0);
                  end else begin
                     mon_e = (m == 0) ? exp_s.pop_front() : exp_l.pop_front();
                     check((m == 0) ? "bit_serp" : "bit_lin", int'(mon_hi[m] == T1H), int'(mon_e));
                  end
               end
               if (mon_in[m]) mon_lo[m]++;
            end
            if (mon_f) begin
               check("latch_len", mon_lo[m], BITC - mon_last[m] + RSTC + 1);
               check("frame_bits", mon_nb[m], NBITS);
               mon_nb[m] = 0;
               mon_in[m] = 1'b0;
            end
            mon_prev[m] = mon_d;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one frame; poke!=0 disturbs start/state mid-frame and in the done cycle.
   task automatic run_frame(logic [NPIX-1:0] st, int on_s, int on_l, int poke);
      int n;
      step();
      state_r = st;
      push_frame(on_s, on_l);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      n = 1;
      check("first_rise", dout_s, 1);
      check("busy_on", busy_s, 1);
      while (!fd_s && n < FRAME + 10) begin
         step();
         n++;
         if (poke != 0 && n == 150) begin
            frame_start = 1'b1;
            state_r     = '1;
         end else if (poke != 0 && n == 151) begin
            frame_start = 1'b0;
         end
      end
      check("done_time", n, FRAME + 1);
      check("busy_off", busy_s, 0);
      check("lin_done", fd_l, 1);
      if (poke != 0) frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      check("done_pulse", fd_s, 0);
      check("start_in_done_ignored", busy_s, 0);
      step();
      check("idle_low", dout_s, 0);
   endtask

   typedef struct {
      logic [NPIX-1:0] st;
      int              on_s;
      int              on_l;
   } vec_t;

   vec_t vec[7];
   int   n;
   int   dones;

   initial begin
      vec[0] = '{16'h0001,  0,  0};
      vec[1] = '{16'h0000, -1, -1};
      vec[2] = '{16'h0010,  7,  4};
      vec[3] = '{16'h0020,  6,  5};
      vec[4] = '{16'h8000, 12, 15};
      vec[5] = '{16'h0100,  8,  8};
      vec[6] = '{16'hFFFF, -2, -2};

      #22;
      check("rst_dout", dout_s, 0);
      check("rst_busy", busy_s, 0);
      check("rst_done", fd_s, 0);
      step();
      rst_n = 1'b1;
      repeat (3) step();
      check("idle_busy", busy_s, 0);

      for (int i = 0; i < 7; i++) run_frame(vec[i].st, vec[i].on_s, vec[i].on_l, 0);

      // Restart attempt and state change mid-frame must not disturb the snapshot.
      run_frame(16'h0010, 7, 4, 1);

      // Asynchronous reset at roughly pixel 10.
      step();
      state_r = 16'h0001;
      push_frame(0, 0);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      n = 1;
      while (n < 10 * 24 * BITC) begin step(); n++; end
      while (!dout_s && n < 12 * 24 * BITC) begin step(); n++; end
      check("pre_rst_high", dout_s, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_dout", dout_s, 0);
      check("async_busy", busy_s, 0);
      check("async_dout_lin", dout_l, 0);
      repeat (3) step();
      rst_n = 1'b1;
      dones = 0;
      for (int c = 0; c < FRAME / 2; c++) begin
         step();
         if (fd_s || fd_l || busy_s) dones++;
      end
      check("no_done_after_rst", dones, 0);
      run_frame(16'h0020, 6, 5, 0);

      // frame_start held high: back-to-back frames with one idle cycle between.
      step();
      state_r = 16'h8000;
      push_frame(12, 15);
      push_frame(12, 15);
      frame_start = 1'b1;
      step();
      n = 1;
      check("b2b_first_rise", dout_s, 1);
      while (!fd_s && n < FRAME + 10) begin step(); n++; end
      check("b2b_done_time", n, FRAME + 1);
      step();
      check("b2b_gap_dout", dout_s, 0);
      check("b2b_gap_busy", busy_s, 0);
      step();
      check("b2b_rise", dout_s, 1);
      check("b2b_busy", busy_s, 1);
      frame_start = 1'b0;
      n = 1;
      while (!fd_s && n < FRAME + 10) begin step(); n++; end
      check("b2b_done_time2", n, FRAME + 1);
      repeat (3) step();
      check("b2b_stream_left", exp_s.size() + exp_l.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
